// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer: word-aligned memory transactions, boundary split, load extension
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAITR, DONE} state_t;

  state_t      state_q;
  logic        part_q, split_q, we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [3:0]  be_hi_q;
  logic [31:0] wdata_q, base_q, lo_q;
  logic [4:0]  rd_q;

  logic        req_ready_q, mem_req_q, mem_we_q, rsp_valid_q, rsp_err_q;
  logic [31:0] mem_addr_q, mem_wdata_q, rsp_rdata_q;
  logic [3:0]  mem_be_q;
  logic [4:0]  rsp_rd_q;

  logic [3:0]  size_m_d;
  logic [7:0]  be8_d;
  logic        illegal_d;
  logic [31:0] p1_addr_d, p1_wdata_d, hi_d, lo_d, s_d, load_res_d;
  logic [3:0]  p1_be_d;

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   size_m_d = 4'b0001;
      2'b01:   size_m_d = 4'b0011;
      default: size_m_d = 4'b1111;
    endcase
    be8_d     = {4'b0000, size_m_d} << req_addr[1:0];
    illegal_d = (req_funct3[1:0] == 2'b11) || (req_funct3[2] && (req_we || req_funct3[1]));
  end

  // Second half of a split: next word, upper byte lanes, the bytes that spilled past lane 3.
  assign p1_addr_d  = base_q + 32'd4;
  assign p1_be_d    = we_q ? be_hi_q : 4'hF;
  assign p1_wdata_d = we_q ? (wdata_q >> (6'd32 - {1'b0, off_q, 3'b000})) : 32'h0;

  // On the final read beat the incoming word is either the only word or the high word.
  always_comb begin
    hi_d = part_q ? mem_rdata : 32'h0;
    lo_d = part_q ? lo_q : mem_rdata;
    s_d  = 32'({hi_d, lo_d} >> {off_q, 3'b000});
    case (funct3_q)
      3'b000:  load_res_d = {{24{s_d[7]}}, s_d[7:0]};
      3'b001:  load_res_d = {{16{s_d[15]}}, s_d[15:0]};
      3'b100:  load_res_d = {24'h0, s_d[7:0]};
      3'b101:  load_res_d = {16'h0, s_d[15:0]};
      default: load_res_d = s_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      part_q      <= 1'b0;
      split_q     <= 1'b0;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      be_hi_q     <= 4'h0;
      wdata_q     <= 32'h0;
      base_q      <= 32'h0;
      lo_q        <= 32'h0;
      rd_q        <= 5'd0;
      req_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_rd_q    <= 5'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q        <= req_we;
          funct3_q    <= req_funct3;
          off_q       <= req_addr[1:0];
          be_hi_q     <= be8_d[7:4];
          wdata_q     <= req_wdata;
          base_q      <= {req_addr[31:2], 2'b00};
          rd_q        <= req_rd;
          part_q      <= 1'b0;
          split_q     <= |be8_d[7:4];
          req_ready_q <= 1'b0;
          if (illegal_d) begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rd_q    <= req_rd;
          end else begin
            state_q     <= ISSUE;
            mem_req_q   <= 1'b1;
            mem_we_q    <= req_we;
            mem_addr_q  <= {req_addr[31:2], 2'b00};
            mem_be_q    <= req_we ? be8_d[3:0] : 4'hF;
            mem_wdata_q <= req_we ? (req_wdata << {req_addr[1:0], 3'b000}) : 32'h0;
          end
        end
        ISSUE: if (mem_gnt) begin
          if (!we_q) begin
            state_q   <= WAITR;
            mem_req_q <= 1'b0;
          end else if (split_q && !part_q) begin
            part_q      <= 1'b1;
            mem_addr_q  <= p1_addr_d;
            mem_be_q    <= p1_be_d;
            mem_wdata_q <= p1_wdata_d;
          end else begin
            state_q     <= DONE;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rd_q    <= rd_q;
          end
        end
        WAITR: if (mem_rvalid) begin
          if (split_q && !part_q) begin
            lo_q        <= mem_rdata;
            part_q      <= 1'b1;
            state_q     <= ISSUE;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= p1_addr_d;
            mem_be_q    <= p1_be_d;
            mem_wdata_q <= p1_wdata_d;
          end else begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
            rsp_rd_q    <= rd_q;
            rsp_rdata_q <= load_res_d;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= 32'h0;
          rsp_rd_q    <= 5'd0;
          rsp_err_q   <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= 32'h0;
          mem_be_q    <= 4'h0;
          mem_wdata_q <= 32'h0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with byte-level reference model
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          g;
    int          r;
  } mtxn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [4:0]  rd;
    int          lat;
  } rsp_t;

  mtxn_t mem_q[$];
  rsp_t  rsp_q[$];
  int    acc_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    busy = 1'b0;
  bit    manual = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic chk_cleared(input string pfx);
    chk({pfx, " req_ready"}, 32'(req_ready), 32'd1);
    chk({pfx, " mem_req"},   32'(mem_req),   32'd0);
    chk({pfx, " mem_we"},    32'(mem_we),    32'd0);
    chk({pfx, " mem_addr"},  mem_addr,       32'd0);
    chk({pfx, " mem_be"},    32'(mem_be),    32'd0);
    chk({pfx, " mem_wdata"}, mem_wdata,      32'd0);
    chk({pfx, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({pfx, " rsp_rdata"}, rsp_rdata,      32'd0);
    chk({pfx, " rsp_rd"},    32'(rsp_rd),    32'd0);
    chk({pfx, " rsp_err"},   32'(rsp_err),   32'd0);
  endtask

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] tag);
    int w;
    w = 0;
    while (!req_ready && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    if (!req_ready) fail("req_ready never returned high");
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_rd     = tag;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_rd     = 5'($urandom);
  endtask

  // Reference model: walk the accessed bytes one at a time and place each in its word/lane.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd0, input logic [31:0] rd1,
                       input int g0, input int r0, input bit use_tab,
                       input logic [31:0] tab_rdata, input logic tab_err);
    int          n, off, nw, lat;
    bit          bad;
    logic [31:0] res;
    logic [31:0] rdw [2];
    logic [4:0]  tag;
    mtxn_t       t;
    rsp_t        e;
    tag = 5'($urandom);
    n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    bad = (f3[1:0] == 2'b11) || (f3[2] && (we || f3[1]));
    off = int'(addr[1:0]);
    rdw[0] = rd0;
    rdw[1] = rd1;
    res = 32'h0;
    lat = 1;
    if (!bad) begin
      nw = (off + n > 4) ? 2 : 1;
      for (int k = 0; k < nw; k++) begin
        t.addr  = {addr[31:2], 2'b00} + 32'(4 * k);
        t.we    = we;
        t.rdata = rdw[k];
        t.g     = (k == 0 && g0 >= 0) ? g0 : int'($urandom_range(0, 2));
        t.r     = (r0 > 0) ? r0 : int'($urandom_range(1, 3));
        t.be    = we ? 4'h0 : 4'hF;
        t.wdata = 32'h0;
        if (we) begin
          for (int l = 0; l < 4; l++) begin
            int src;
            src = 4 * k + l - off;
            if (src >= 0 && src < 4) t.wdata[8*l +: 8] = wd[8*src +: 8];
            if (src >= 0 && src < n) t.be[l] = 1'b1;
          end
        end
        lat += t.g + 1 + (we ? 0 : t.r);
        mem_q.push_back(t);
      end
      if (!we) begin
        for (int i = 0; i < n; i++) begin
          int p;
          p = off + i;
          res[8*i +: 8] = rdw[p / 4][8*(p % 4) +: 8];
        end
        if (!f3[2] && n < 4 && res[8*n-1])
          for (int i = n; i < 4; i++) res[8*i +: 8] = 8'hFF;
      end
    end
    e.rdata = use_tab ? tab_rdata : res;
    e.err   = use_tab ? tab_err : bad;
    e.rd    = tag;
    e.lat   = lat;
    rsp_q.push_back(e);
    drive_req(we, f3, addr, wd, tag);
  endtask

  // Memory responder: checks each transaction against the expected queue, then grants/returns data.
  initial begin
    mtxn_t t;
    forever begin
      @(negedge clk);
      if (!manual && rst_n && mem_req) begin
        if (mem_q.size() == 0) begin
          fail("mem_req with no transaction expected");
          mem_gnt = 1'b1;
          @(posedge clk); #1;
          mem_gnt = 1'b0;
        end else begin
          t = mem_q.pop_front();
          chk("mem_addr", mem_addr, t.addr);
          chk("mem_we", 32'(mem_we), 32'(t.we));
          chk("mem_be", 32'(mem_be), 32'(t.be));
          if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
          for (int w = 0; w < t.g; w++) begin
            if (!t.we) begin
              mem_rvalid = 1'($urandom);
              mem_rdata  = $urandom;
            end
            @(negedge clk);
            chk("mem_req held", 32'(mem_req), 32'd1);
            chk("mem_addr held", mem_addr, t.addr);
            chk("mem_be held", 32'(mem_be), 32'(t.be));
            if (t.we) chk("mem_wdata held", mem_wdata, t.wdata);
          end
          mem_rvalid = 1'b0;
          mem_gnt    = 1'b1;
          @(posedge clk); #1;
          mem_gnt = 1'b0;
          if (!t.we) begin
            for (int w = 1; w < t.r; w++) begin
              @(posedge clk); #1;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = t.rdata;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
          end
        end
      end
    end
  end

  // Response monitor: handshake timestamps, req_ready tracking, response comparison.
  initial begin
    rsp_t e;
    int   a;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0;
        acc_q.delete();
      end else begin
        chk("req_ready", 32'(req_ready), 32'(!busy));
        if (req_valid && req_ready) begin
          acc_q.push_back(cyc);
          busy = 1'b1;
        end
        if (rsp_valid) begin
          if (rsp_q.size() == 0 || acc_q.size() == 0) begin
            fail("rsp_valid with no request outstanding");
          end else begin
            e = rsp_q.pop_front();
            a = acc_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_rd", 32'(rsp_rd), 32'(e.rd));
            chk("rsp latency", 32'(cyc - a), 32'(e.lat));
          end
          busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          w;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [2:0]  ld_codes [5];
    ld_codes[0] = 3'b000; ld_codes[1] = 3'b001; ld_codes[2] = 3'b010;
    ld_codes[3] = 3'b100; ld_codes[4] = 3'b101;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cleared("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'h89AB_CDEF, 32'h0, 0, 1, 1'b1, 32'h89AB_CDEF, 1'b0);
    issue(1'b0, 3'b000, 32'h0000_2003, 32'h0, 32'h80FF_7F01, 32'h0, 0, 1, 1'b1, 32'hFFFF_FF80, 1'b0);
    issue(1'b0, 3'b100, 32'h0000_2003, 32'h0, 32'h80FF_7F01, 32'h0, 0, 1, 1'b1, 32'h0000_0080, 1'b0);
    issue(1'b0, 3'b101, 32'h0000_2003, 32'h0, 32'hAB00_0000, 32'h0000_00CD, 0, 1, 1'b1, 32'h0000_CDAB, 1'b0);
    issue(1'b0, 3'b001, 32'h0000_2003, 32'h0, 32'hAB00_0000, 32'h0000_00CD, 0, 1, 1'b1, 32'hFFFF_CDAB, 1'b0);
    issue(1'b1, 3'b010, 32'h0000_3002, 32'h1122_3344, 32'h0, 32'h0, 2, 1, 1'b1, 32'h0, 1'b0);
    issue(1'b1, 3'b100, 32'h0000_0040, 32'h0000_5555, 32'h0, 32'h0, 0, 1, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, 32'h0, 32'h0, 0, 1, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 3'b011, 32'h0000_0044, 32'h0, 32'h0, 32'h0, 0, 1, 1'b1, 32'h0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
      else if (we) f3 = 3'($urandom_range(0, 2));
      else f3 = ld_codes[$urandom_range(0, 4)];
      addr = $urandom;
      if ($urandom_range(0, 9) == 0) addr[31:2] = 30'h3FFF_FFFF;
      issue(we, f3, addr, $urandom, $urandom, $urandom, -1, 0, 1'b0, 32'h0, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    w = 0;
    while ((rsp_q.size() != 0 || busy) && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("responses drained", 32'(rsp_q.size()), 32'd0);
    chk("transactions drained", 32'(mem_q.size()), 32'd0);

    manual = 1'b1;
    drive_req(1'b0, 3'b010, 32'h0000_1000, 32'h0, 5'd7);
    w = 0;
    while (!mem_req && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    chk("reset test mem_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_cleared("mid-op reset");
    @(posedge clk);
    @(posedge clk); #1;
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("stale rvalid rsp_valid", 32'(rsp_valid), 32'd0);
      chk("stale rvalid mem_req", 32'(mem_req), 32'd0);
    end
    @(posedge clk); #1;
    manual = 1'b0;

    issue(1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'h0123_4567, 32'h0, 0, 1, 1'b1, 32'h0123_4567, 1'b0);
    w = 0;
    while ((rsp_q.size() != 0 || busy) && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk("post-reset response drained", 32'(rsp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencing controller between the execute stage and the data-memory port. Accepts one load or store per handshake, generates word-aligned memory transactions with byte enables, and splits any access that crosses a 32-bit word boundary into two transactions. Merges, aligns and sign/zero-extends load data, then returns a single response to the writeback stage.

## Interface
- No parameters; data width is fixed at 32 bits and address width at 32 bits.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_rd  in  5  destination register tag, returned unchanged.
- mem_req  out  1  memory transaction valid.
- mem_gnt  in  1  memory accepts the transaction this cycle.
- mem_we  out  1  transaction is a write.
- mem_addr  out  32  word address; bits [1:0] always 0.
- mem_be  out  4  active-high byte enables; 1111 for all reads.
- mem_wdata  out  32  lane-shifted write data.
- mem_rvalid  in  1  read data valid; at least one cycle after the granting edge.
- mem_rdata  in  32  read data.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  32  extended load result; 0 for stores and errors.
- rsp_rd  out  5  tag of the completed request.
- rsp_err  out  1  illegal funct3 (load 011/11x, store 011/1xx).

## Operation
- State machine has four states: IDLE, ISSUE, WAITR and DONE.
- IDLE, on req_valid:
  - Latch the request into the command registers and compute off = addr[1:0].
  - Size mask m = 0001/0011/1111 for B/H/W.
  - be8 = m << off, an 8-bit value.
  - Split is required when be8[7:4] != 0.
  - Go to ISSUE with part = 0. Illegal funct3 goes directly to DONE with rsp_err = 1, and no memory traffic occurs.
- ISSUE:
  - mem_req = 1, and mem_addr/mem_be/mem_wdata stay stable until mem_gnt.
  - Part 0: addr = {addr[31:2], 00}, be = be8[3:0], wdata = req_wdata << 8*off.
  - Part 1: addr = part-0 addr + 4, wrapping mod 2^32 (0xFFFFFFFC + 4 = 0x00000000); be = be8[7:4]; wdata = req_wdata >> 8*(4-off).
  - On mem_gnt, loads go to WAITR.
  - On mem_gnt, stores go to ISSUE part 1 if a split is pending, else to DONE.
- WAITR:
  - On mem_rvalid, store mem_rdata into lo (part 0) or hi (part 1).
  - Then go to ISSUE part 1 if a split is pending, else to DONE.
  - mem_rvalid is ignored in every other state.
- DONE:
  - rsp_valid = 1 for one cycle, then return to IDLE.
  - Load result: s = {hi, lo} >> 8*off, with hi = 0 when there was no split.
  - B/H sign-extend from s[7] and s[15] respectively; BU/HU zero-extend; W passes s[31:0].
- Reset, including mid-transaction: return to IDLE and discard the request.
  - Outputs after reset: req_ready = 1; all other outputs 0.
  - A stale mem_rvalid arriving after reset is ignored.

## Timing
- A request is accepted at edge T when req_valid && req_ready.
- mem_req is registered and asserts from cycle T+1.
- Aligned load with immediate grant and rvalid one cycle later: rsp_valid in cycle T+3.
- Aligned store with immediate grant: rsp_valid in cycle T+2.
- Each split adds 2 cycles for loads and 1 cycle for stores; each grant or rvalid wait cycle adds 1.
- Illegal request: rsp_valid in cycle T+1.
- Back-to-back operation: req_ready returns high the cycle after rsp_valid.
- mem_req never deasserts without a grant.

## Test plan
- LW at 0x1000, rdata 0x89ABCDEF:
  - Required: one transaction at addr 0x1000, be 1111.
  - Required: rsp_rdata = 0x89ABCDEF, rsp_valid at T+3, req_ready low from T+1 to T+3.
- LB at 0x2003, rdata 0x80FF7F01:
  - Required: rsp_rdata = 0xFFFFFF80.
  - Repeat as LBU: required rsp_rdata = 0x00000080.
- LHU at 0x2003, part 0 rdata 0xAB000000, part 1 rdata 0x000000CD:
  - Required: two reads, at 0x2000 then 0x2004.
  - Required: rsp_rdata = 0x0000CDAB. The LH variant returns 0xFFFFCDAB.
- SW 0x11223344 at 0x3002, mem_gnt delayed 2 cycles on part 0:
  - Part 0 required: addr 0x3000, be 1100, wdata 0x33440000, held stable while waiting.
  - Part 1 required: addr 0x3004, be 0011, wdata 0x00001122.
- Store with funct3 100:
  - Required: no mem_req, rsp_valid with rsp_err = 1 at T+1.
- SH at 0xFFFFFFFF:
  - Required: part 1 addr 0x00000000, be 0001.
- Reset mid-operation:
  - Assert rst_n = 0 while in WAITR, then deliver mem_rvalid after release.
  - Required: outputs cleared and no rsp_valid.
